// File: rtl/imm_encoder.sv
// RV32I encoder (LI->LUI/ADDI, JAL, BRANCH, STORE): first word 1 cycle after accept, range error pulses instead.
// Words are held under out_ready backpressure; req_ready is high only while idle.
module imm_encoder #(
   parameter bit SHORT_LI = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_last,
   output logic        err_range
);

   typedef enum logic [1:0] {IDLE, EMIT1, EMIT2, ERR} state_t;

   localparam logic [1:0] OP_LI     = 2'b00;
   localparam logic [1:0] OP_JAL    = 2'b01;
   localparam logic [1:0] OP_BRANCH = 2'b10;
   localparam logic [1:0] OP_STORE  = 2'b11;

   state_t      state;
   logic [31:0] word2;

   logic [11:0] lo;
   logic [19:0] hi;
   logic        fits12;
   logic        bad;
   logic        single;
   logic [31:0] w1;
   logic [31:0] w2;

   assign req_ready = (state == IDLE);

   always_comb begin
      lo     = req_imm[11:0];
      // hi absorbs the sign of lo so that LUI+ADDI reconstructs the full value
      hi     = req_imm[31:12] + {19'd0, req_imm[11]};
      fits12 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
      bad    = 1'b0;
      single = 1'b1;
      w1     = 32'd0;
      w2     = 32'd0;
      case (req_op)
         OP_LI: begin
            if (SHORT_LI && fits12) begin
               w1 = {lo, 5'd0, 3'b000, req_rd, 7'b0010011};
            end else if (lo == 12'd0) begin
               w1 = {hi, req_rd, 7'b0110111};
            end else begin
               w1     = {hi, req_rd, 7'b0110111};
               w2     = {lo, req_rd, 3'b000, req_rd, 7'b0010011};
               single = 1'b0;
            end
         end
         OP_JAL: begin
            bad = req_imm[0] | ~((&req_imm[31:20]) | ~(|req_imm[31:20]));
            w1  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                   req_rd, 7'b1101111};
         end
         OP_BRANCH: begin
            bad = req_imm[0] | ~((&req_imm[31:12]) | ~(|req_imm[31:12]));
            w1  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                   req_imm[4:1], req_imm[11], 7'b1100011};
         end
         default: begin
            bad = ~fits12;
            w1  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0],
                   7'b0100011};
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_inst  <= 32'd0;
         out_last  <= 1'b0;
         err_range <= 1'b0;
         word2     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (bad) begin
                     err_range <= 1'b1;
                     state     <= ERR;
                  end else begin
                     out_valid <= 1'b1;
                     out_inst  <= w1;
                     out_last  <= single;
                     word2     <= w2;
                     state     <= EMIT1;
                  end
               end
            end
            EMIT1: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_inst  <= 32'd0;
                     out_last  <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     out_inst <= word2;
                     out_last <= 1'b1;
                     state    <= EMIT2;
                  end
               end
            end
            EMIT2: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_inst  <= 32'd0;
                  out_last  <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               err_range <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
